// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and width helper for the button debouncer
// Purpose: holds the default timing values for the 100 MHz board clock and the
// clog2 helper used to size the debounce and long-press counters.
// Ports: none (package).
package debounce_pkg;

  // 65536 cycles at 100 MHz is about 655 us of required stability.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 65536;
  // 50,000,000 cycles at 100 MHz is a 0.5 s hold for a long press.
  localparam int unsigned DEFAULT_LONG_CYCLES   = 50_000_000;

  // Ceiling log2 with a floor of 1, so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((longint'(1) << width) < longint'(value)) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchroniser, debounce and long-press timing
// Purpose: synchronises a polarity-corrected pin, debounces both edges
// symmetrically and generates press/release/long-press pulses.
// Ports:
//   clk_i        - system clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   pin_i        - raw pin, already corrected so 1 = pressed
//   level_o      - debounced pressed state
//   press_o      - one-cycle pulse on level 0->1
//   release_o    - one-cycle pulse on level 1->0
//   long_press_o - one-cycle pulse once per press after the hold time
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int unsigned CNT_W  = clog2(STABLE_CYCLES);
  localparam int unsigned LONG_W = clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [LONG_W-1:0] HOLD_MAX  = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] HOLD_FIRE = LONG_W'(LONG_CYCLES - 1);

  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  always_comb begin
    s0_d      = pin_i;
    s1_d      = s0_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    // Any cycle where the synchronised pin agrees with the level restarts
    // the stability count, so only an uninterrupted run can flip the level.
    if (s1_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d   = s1_q;
      cnt_d     = '0;
      press_d   = s1_q;
      release_d = ~s1_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Hold time counts only while the level stays high across this edge;
    // the falling edge itself clears it. Saturation gives a single pulse.
    hold_d = '0;
    long_d = 1'b0;
    if (level_q && level_d) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + LONG_W'(1);
      long_d = (hold_q == HOLD_FIRE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel push-button conditioner
// Purpose: applies optional pin inversion and instantiates one independent
// debounce channel per button.
// Ports:
//   clk_i        - system clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   button_i     - raw asynchronous pins, N_CH wide
//   level_o      - debounced pressed state per channel
//   press_o      - per-channel one-cycle press pulse
//   release_o    - per-channel one-cycle release pulse
//   long_press_o - per-channel one-cycle long-press pulse
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter bit          ACTIVE_HIGH   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o
);

  // Normalise polarity before the synchroniser so every channel sees 1 = pressed.
  logic [N_CH-1:0] pin;
  assign pin = ACTIVE_HIGH ? button_i : ~button_i;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES)
    ) u_channel (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .pin_i        (pin[ch]),
      .level_o      (level_o[ch]),
      .press_o      (press_o[ch]),
      .release_o    (release_o[ch]),
      .long_press_o (long_press_o[ch])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - directed self-checking bench for debounce_bank
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] button = 4'b0000;
  logic [3:0] level, press, rel, long_p;
  logic       button_inv = 1'b1;
  logic [0:0] level_inv, press_inv, rel_inv, long_inv;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(4), .STABLE_CYCLES(8), .LONG_CYCLES(20), .ACTIVE_HIGH(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .button_i(button),
    .level_o(level), .press_o(press), .release_o(rel), .long_press_o(long_p)
  );

  debounce_bank #(
    .N_CH(1), .STABLE_CYCLES(8), .LONG_CYCLES(20), .ACTIVE_HIGH(1'b0)
  ) dut_inv (
    .clk_i(clk), .rst_ni(rst_n), .button_i(button_inv),
    .level_o(level_inv), .press_o(press_inv), .release_o(rel_inv), .long_press_o(long_inv)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_level", 0, level, 0);
    chk("rst_pulses", 0, {press, rel, long_p}, 0);
    chk("rst_inv_level", 0, level_inv, 0);
    step();
    step();
    @(negedge clk) rst_n = 1'b1;

    // Clean press on ch0 before edge 10, release before edge 46.
    for (int e = 1; e <= 60; e++) begin
      if (e == 10) button[0] = 1'b1;
      if (e == 46) button[0] = 1'b0;
      step();
      chk("clean_level", e, level[0], (e >= 19 && e < 55));
      chk("clean_press", e, press[0], (e == 19));
      chk("clean_release", e, rel[0], (e == 55));
      chk("clean_long", e, long_p[0], (e == 39));
      chk("clean_others", e, level[3:1], 0);
      chk("clean_inv_idle", e, level_inv, 0);
    end

    // Bounce on ch1 (settles at i=40), ch0 bouncing throughout, ch2/ch3 together at i=5.
    for (int i = 0; i <= 60; i++) begin
      button[0] = ((i % 6) < 3);
      button[1] = (i >= 40) ? 1'b1 : ((i % 6) < 3);
      button[2] = (i >= 5);
      button[3] = (i >= 5);
      step();
      chk("bounce_ch0_level", i, level[0], 0);
      chk("bounce_ch0_press", i, press[0], 0);
      chk("bounce_ch1_level", i, level[1], (i >= 49));
      chk("bounce_ch1_press", i, press[1], (i == 49));
      chk("indep_press23", i, press[3:2], (i == 14) ? 2'b11 : 2'b00);
      chk("indep_level23", i, level[3:2], (i >= 14) ? 2'b11 : 2'b00);
      chk("indep_long23", i, long_p[3:2], (i == 34) ? 2'b11 : 2'b00);
      chk("bounce_ch1_long", i, long_p[1], 0);
    end
    button = 4'b0000;
    for (int i = 0; i < 12; i++) step();
    chk("idle_level", 0, level, 0);

    // Short press on ch3: 12 cycles high.
    for (int j = 0; j <= 35; j++) begin
      button[3] = (j < 12);
      step();
      chk("short_press", j, press[3], (j == 9));
      chk("short_release", j, rel[3], (j == 21));
      chk("short_level", j, level[3], (j >= 9 && j < 21));
      chk("short_long", j, long_p[3], 0);
    end

    // Reset mid-count: ch1 already pressed, ch2 at count 5.
    button[1] = 1'b1;
    for (int j = 0; j < 12; j++) step();
    chk("pre_rst_level", 0, level, 4'b0010);
    button[2] = 1'b1;
    for (int j = 0; j <= 6; j++) step();
    chk("pre_rst_level", 1, level, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 0, level, 0);
    chk("midrst_pulses", 0, {press, rel, long_p}, 0);
    step();
    chk("midrst_hold", 1, {level, press, rel, long_p}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("post_rst_press", e, press, (e == 10) ? 4'b0110 : 4'b0000);
      chk("post_rst_level", e, level, (e >= 10) ? 4'b0110 : 4'b0000);
      chk("post_rst_release", e, rel, 0);
    end

    // Inverted build: pin low for 10 cycles.
    for (int j = 0; j <= 22; j++) begin
      button_inv = (j >= 10);
      step();
      chk("inv_press", j, press_inv, (j == 9));
      chk("inv_level", j, level_inv, (j >= 9 && j < 19));
      chk("inv_release", j, rel_inv, (j == 19));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
